// File: rtl/opener_motor_pkg.sv
// Shared types and defaults for the garage-door opener motor driver.
// State encoding, default timing constants and the idle-style next-state decode.
package opener_motor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE_UP = 2'd1,
    DRIVE_DN = 2'd2,
    DEAD     = 2'd3
  } mstate_e;

  localparam int DEF_DEAD_CYCLES = 4;
  localparam int DEF_MAX_TRAVEL  = 64;
  localparam int DEF_CNT_W       = 8;

  // Shared by IDLE and the last DEAD cycle; a latched fault blocks any new drive.
  function automatic mstate_e idle_decode(input logic req_up,
                                          input logic req_dn,
                                          input logic flt);
    mstate_e nxt;
    if (flt) begin
      nxt = IDLE;
    end else if (req_up) begin
      nxt = DRIVE_UP;
    end else if (req_dn) begin
      nxt = DRIVE_DN;
    end else begin
      nxt = IDLE;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/opener_cycle_timer.sv
// Loadable down-counter that saturates at zero; used for travel and dead timing.
module opener_cycle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             r,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Counter register: reset, then load, then decrement while enabled and nonzero.
  always_ff @(posedge clk) begin
    if (r) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/opener_motor_driver.sv
// Motor drive stage: exclusive mu/md, dead-time on every stop, latched travel timeout.
// Optional brake output and braked reset enabled by OPENER_MOTOR_BRAKE_EN.
module opener_motor_driver
  import opener_motor_pkg::*;
#(
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int MAX_TRAVEL  = DEF_MAX_TRAVEL,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       r,
  input  logic       u,
  input  logic       d,
  input  logic       clr,
  output logic       mu,
  output logic       md,
  output logic       brk,
  output logic       fault,
  output logic [1:0] mstate
);

  localparam logic [CNT_W-1:0] TRAV_LOAD = CNT_W'(MAX_TRAVEL - 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

  mstate_e state_r;
  mstate_e nxt_s;
  logic    mu_r;
  logic    md_r;
  logic    fault_r;
  logic    req_up_s;
  logic    req_dn_s;
  logic    timeout_s;
  logic    trav_load_s;
  logic    trav_en_s;
  logic    trav_zero_s;
  logic    dead_load_s;
  logic    dead_en_s;
  logic    dead_zero_s;
  logic    rst_brake_s;

  assign req_up_s = u & ~d;
  assign req_dn_s = d & ~u;

`ifdef OPENER_MOTOR_BRAKE_EN
  logic brk_r;
  // A reset that lands mid-drive brakes through a full dead period instead of idling.
  assign rst_brake_s = r & (mu_r | md_r);
  assign brk         = brk_r;
`else
  assign rst_brake_s = 1'b0;
  assign brk         = 1'b0;
`endif

  // Next-state decode and timer control.
  always_comb begin
    nxt_s     = state_r;
    timeout_s = 1'b0;
    trav_en_s = 1'b0;
    dead_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        nxt_s = idle_decode(req_up_s, req_dn_s, fault_r);
      end
      DRIVE_UP: begin
        trav_en_s = 1'b1;
        if (!req_up_s) begin
          nxt_s = DEAD;
        end else if (trav_zero_s) begin
          nxt_s     = DEAD;
          timeout_s = 1'b1;
        end else begin
          nxt_s = DRIVE_UP;
        end
      end
      DRIVE_DN: begin
        trav_en_s = 1'b1;
        if (!req_dn_s) begin
          nxt_s = DEAD;
        end else if (trav_zero_s) begin
          nxt_s     = DEAD;
          timeout_s = 1'b1;
        end else begin
          nxt_s = DRIVE_DN;
        end
      end
      DEAD: begin
        dead_en_s = 1'b1;
        if (dead_zero_s) begin
          nxt_s = idle_decode(req_up_s, req_dn_s, fault_r);
        end else begin
          nxt_s = DEAD;
        end
      end
      default: begin
        nxt_s = IDLE;
      end
    endcase
    trav_load_s = ((nxt_s == DRIVE_UP) || (nxt_s == DRIVE_DN)) && (nxt_s != state_r);
    dead_load_s = ((nxt_s == DEAD) && (state_r != DEAD)) || rst_brake_s;
  end

  // State, drive outputs and fault latch; drives are decoded from the next state.
  always_ff @(posedge clk) begin
    if (r) begin
      fault_r <= 1'b0;
      mu_r    <= 1'b0;
      md_r    <= 1'b0;
`ifdef OPENER_MOTOR_BRAKE_EN
      if (mu_r | md_r) begin
        state_r <= DEAD;
        brk_r   <= 1'b1;
      end else begin
        state_r <= IDLE;
        brk_r   <= 1'b0;
      end
`else
      state_r <= IDLE;
`endif
    end else begin
      state_r <= nxt_s;
      mu_r    <= (nxt_s == DRIVE_UP);
      md_r    <= (nxt_s == DRIVE_DN);
`ifdef OPENER_MOTOR_BRAKE_EN
      brk_r   <= (nxt_s == DEAD);
`endif
      // A timeout in the same cycle as clr keeps the fault set.
      if (timeout_s) begin
        fault_r <= 1'b1;
      end else if (clr) begin
        fault_r <= 1'b0;
      end else begin
        fault_r <= fault_r;
      end
    end
  end

  opener_cycle_timer #(.CNT_W(CNT_W)) u_trav_timer (
    .clk      (clk),
    .r        (r),
    .load     (trav_load_s),
    .load_val (TRAV_LOAD),
    .en       (trav_en_s),
    .zero     (trav_zero_s)
  );

  opener_cycle_timer #(.CNT_W(CNT_W)) u_dead_timer (
    .clk      (clk),
    .r        (r & ~rst_brake_s),
    .load     (dead_load_s),
    .load_val (DEAD_LOAD),
    .en       (dead_en_s),
    .zero     (dead_zero_s)
  );

  assign mu     = mu_r;
  assign md     = md_r;
  assign fault  = fault_r;
  assign mstate = state_r;

endmodule
